// File: rtl/wait_event_sequencer.sv
// Wait-command sequencer: buffers commands in a FIFO, issues them one at a time to the
// wait-event checker, retires each on wait_done or guard watchdog. Optional abort: WAIT_EVENT_SEQ_ABORT_EN.
module wait_event_sequencer #(
    parameter int WAIT_SIZE    = 8,
    parameter int WAIT_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef WAIT_EVENT_SEQ_ABORT_EN
    input  logic                         i_abort,
`endif
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [$clog2(WAIT_SIZE)-1:0] i_cmd_sel,
    input  logic                         i_cmd_edge,
    input  logic [WAIT_WIDTH-1:0]        i_cmd_timeout,
    output logic [WAIT_SIZE-1:0]         o_wait_en,
    output logic                         o_sel_wtr_wtf,
    output logic [WAIT_WIDTH-1:0]        o_max_timeout,
    input  logic                         i_wait_done,
    output logic                         o_cmd_done,
    output logic                         o_cmd_err,
    output logic                         o_busy,
    output logic [CNT_WIDTH-1:0]         o_done_cnt,
    output logic [CNT_WIDTH-1:0]         o_err_cnt
);

    localparam int SEL_W = $clog2(WAIT_SIZE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WD_W  = WAIT_WIDTH + 1;
    localparam int CMD_W = SEL_W + 1 + WAIT_WIDTH;
    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [WD_W-1:0]    WD_ONE  = WD_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic abort;
`ifdef WAIT_EVENT_SEQ_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // Command handshake: a command is taken on a rising edge where i_cmd_valid && o_cmd_ready;
    // o_cmd_ready depends only on FIFO occupancy (and abort), never on i_cmd_valid.
    logic [CMD_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr, count;
    logic                  full, empty, push, pop;
    logic [SEL_W-1:0]      head_sel;
    logic                  head_edge;
    logic [WAIT_WIDTH-1:0] head_timeout;

    assign count       = wr_ptr - rd_ptr;
    assign full        = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty       = (wr_ptr == rd_ptr);
    assign o_cmd_ready = !full && !abort;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state == S_IDLE) && !empty && !abort;
    assign {head_sel, head_edge, head_timeout} = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {i_cmd_sel, i_cmd_edge, i_cmd_timeout};
    end

    // Out-of-range selects issue no enable; such a command can only end via the watchdog.
    logic [WAIT_SIZE-1:0] sel_onehot;
    always_comb begin
        sel_onehot = '0;
        if (int'(head_sel) < WAIT_SIZE) sel_onehot[head_sel] = 1'b1;
    end

    logic [WD_W-1:0] watchdog, wd_limit;
    logic            wd_hit, status_err, err_nxt;

    assign wd_limit = {1'b0, o_max_timeout} + WD_W'(GUARD_CYCLES);
    assign wd_hit   = (o_max_timeout != '0) && (watchdog == wd_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // A checker done in the same cycle as the watchdog match counts as success.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: if (pop) state_nxt = S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end else if (i_wait_done) begin
                    state_nxt = S_DONE;
                end else if (wd_hit) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wait_en     <= '0;
            o_sel_wtr_wtf <= 1'b0;
            o_max_timeout <= '0;
            watchdog      <= '0;
            status_err    <= 1'b0;
            o_done_cnt    <= '0;
            o_err_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_wait_en     <= sel_onehot;
                        o_sel_wtr_wtf <= head_edge;
                        o_max_timeout <= head_timeout;
                        watchdog      <= '0;
                    end
                end
                S_WAIT: begin
                    if (watchdog != '1) watchdog <= watchdog + WD_ONE;
                    if (state_nxt == S_DONE) begin
                        o_wait_en  <= '0;
                        status_err <= err_nxt;
                    end
                end
                S_DONE: begin
                    if (status_err) begin
                        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_ONE;
                    end else begin
                        if (o_done_cnt != '1) o_done_cnt <= o_done_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_done = (state == S_DONE);
    assign o_cmd_err  = (state == S_DONE) && status_err;
    assign o_busy     = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_wait_event_sequencer.sv
// Directed and randomized bench for wait_event_sequencer; the reference model predicts
// issue order, retire cycle and status from the command fields and the checker's done timing.
module tb_wait_event_sequencer;

    localparam int WS = 8;
    localparam int WW = 32;
    localparam int FD = 4;
    localparam int GC = 16;
    localparam int CW = 16;
    localparam int CMD_W = 3 + 1 + WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [2:0]    i_cmd_sel = '0;
    logic          i_cmd_edge = 1'b0;
    logic [WW-1:0] i_cmd_timeout = '0;
    logic [WS-1:0] o_wait_en;
    logic          o_sel_wtr_wtf;
    logic [WW-1:0] o_max_timeout;
    logic          i_wait_done = 1'b0;
    logic          o_cmd_done;
    logic          o_cmd_err;
    logic          o_busy;
    logic [CW-1:0] o_done_cnt;
    logic [CW-1:0] o_err_cnt;
`ifdef WAIT_EVENT_SEQ_ABORT_EN
    logic          i_abort = 1'b0;
`endif

    always #5 clk = ~clk;

    wait_event_sequencer #(
        .WAIT_SIZE(WS), .WAIT_WIDTH(WW), .FIFO_DEPTH(FD), .GUARD_CYCLES(GC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef WAIT_EVENT_SEQ_ABORT_EN
        .i_abort(i_abort),
`endif
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_sel(i_cmd_sel),
        .i_cmd_edge(i_cmd_edge),
        .i_cmd_timeout(i_cmd_timeout),
        .o_wait_en(o_wait_en),
        .o_sel_wtr_wtf(o_sel_wtr_wtf),
        .o_max_timeout(o_max_timeout),
        .i_wait_done(i_wait_done),
        .o_cmd_done(o_cmd_done),
        .o_cmd_err(o_cmd_err),
        .o_busy(o_busy),
        .o_done_cnt(o_done_cnt),
        .o_err_cnt(o_err_cnt)
    );

    int errors = 0;
    int checks = 0;
    logic [CMD_W-1:0] exp_q[$];
    int exp_ok = 0;
    int exp_err = 0;
    logic [2:0]    cur_sel;
    logic          cur_edge;
    logic [WW-1:0] cur_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] sel, input logic edge_r, input logic [WW-1:0] to);
        logic exp_rdy;
        exp_rdy       = (exp_q.size() < FD);
        i_cmd_valid   = 1'b1;
        i_cmd_sel     = sel;
        i_cmd_edge    = edge_r;
        i_cmd_timeout = to;
        chk("cmd_ready", o_cmd_ready, exp_rdy);
        if (exp_rdy) exp_q.push_back({sel, edge_r, to});
        tick;
        i_cmd_valid = 1'b0;
    endtask

    // Waits for the next enable and checks it against the oldest queued command.
    task automatic issue(input int exp_lat);
        int n;
        logic [WS-1:0] en_exp;
        n = 0;
        while (o_wait_en == '0 && n < 20) begin
            tick;
            n++;
        end
        chk("issue_latency", n, exp_lat);
        if (exp_q.size() > 0) {cur_sel, cur_edge, cur_to} = exp_q.pop_front();
        en_exp = WS'(1) << cur_sel;
        chk("wait_en", o_wait_en, en_exp);
        chk("sel_wtr_wtf", o_sel_wtr_wtf, cur_edge);
        chk("max_timeout", o_max_timeout, cur_to);
    endtask

    // k0: WAIT cycles already elapsed; dd: WAIT cycle index where checker done is driven (-1 = never).
    task automatic finish_cmd(input int k0, input int dd);
        int k;
        int end_idx;
        logic exp_e;
        logic stable;
        logic seen;
        logic [WS-1:0] en_exp;
        en_exp = WS'(1) << cur_sel;
        if (dd >= 0 && (cur_to == 0 || dd <= int'(cur_to) + GC)) begin
            end_idx = dd;
            exp_e   = 1'b0;
        end else begin
            end_idx = int'(cur_to) + GC;
            exp_e   = 1'b1;
        end
        stable = 1'b1;
        seen   = 1'b0;
        k      = k0;
        while (!seen && k <= end_idx + 20) begin
            i_wait_done = (k == dd);
            if (o_wait_en !== en_exp) stable = 1'b0;
            tick;
            i_wait_done = 1'b0;
            if (o_cmd_done === 1'b1) seen = 1'b1;
            else k++;
        end
        chk("retire_cycle", k, end_idx);
        chk("wait_en_stable", stable, 1'b1);
        chk("cmd_done", o_cmd_done, 1'b1);
        chk("cmd_err", o_cmd_err, exp_e);
        chk("wait_en_in_done", o_wait_en, '0);
        if (exp_e) exp_err++;
        else exp_ok++;
        tick;
        chk("cmd_done_single", o_cmd_done, 1'b0);
        chk("wait_en_gap", o_wait_en, '0);
        chk("done_cnt", o_done_cnt, exp_ok);
        chk("err_cnt", o_err_cnt, exp_err);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic seen_done;
        logic [2:0] s;
        logic e;
        logic [WW-1:0] to;
        int dd;

        // Reset
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick;
        chk("rst_cmd_ready", o_cmd_ready, 1'b1);
        chk("rst_wait_en", o_wait_en, '0);
        chk("rst_sel_wtr_wtf", o_sel_wtr_wtf, 1'b0);
        chk("rst_max_timeout", o_max_timeout, '0);
        chk("rst_cmd_done", o_cmd_done, 1'b0);
        chk("rst_cmd_err", o_cmd_err, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done_cnt", o_done_cnt, '0);
        chk("rst_err_cnt", o_err_cnt, '0);

        // Checker done while idle is ignored
        i_wait_done = 1'b1;
        tick;
        i_wait_done = 1'b0;
        chk("idle_done_ignored", o_cmd_done, 1'b0);
        tick;
        chk("idle_done_cnt", o_done_cnt, '0);

        // Single command, done 10 cycles into the wait
        push_cmd(3'd3, 1'b1, 32'd100);
        chk("queued_not_issued", o_wait_en, '0);
        chk("busy_queued", o_busy, 1'b1);
        issue(1);
        finish_cmd(0, 10);

        // Watchdog retire, timeout 20
        push_cmd(3'd5, 1'b0, 32'd20);
        issue(1);
        finish_cmd(0, -1);

        // Done on the watchdog match cycle wins
        push_cmd(3'd0, 1'b1, 32'd5);
        issue(1);
        finish_cmd(0, 5 + GC);

        // Fill FIFO behind an in-flight command; a sixth push is refused
        push_cmd(3'd1, 1'b1, 32'd0);
        issue(1);
        push_cmd(3'd2, 1'b0, 32'd40);
        push_cmd(3'd4, 1'b1, 32'd3);
        push_cmd(3'd6, 1'b0, 32'd12);
        push_cmd(3'd7, 1'b1, 32'd25);
        push_cmd(3'd5, 1'b1, 32'd9);
        chk("full_ready_low", o_cmd_ready, 1'b0);
        finish_cmd(5, 8);
        issue(1);
        finish_cmd(0, 7);
        issue(1);
        finish_cmd(0, -1);
        issue(1);
        finish_cmd(0, 30);
        issue(1);
        finish_cmd(0, 2);
        chk("drained_busy", o_busy, 1'b0);
        chk("drained_ready", o_cmd_ready, 1'b1);

        // Asynchronous reset mid-wait with three queued
        push_cmd(3'd2, 1'b1, 32'd0);
        issue(1);
        push_cmd(3'd3, 1'b0, 32'd10);
        push_cmd(3'd4, 1'b1, 32'd10);
        push_cmd(3'd5, 1'b0, 32'd10);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_wait_en", o_wait_en, '0);
        chk("arst_cmd_ready", o_cmd_ready, 1'b1);
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_cmd_done", o_cmd_done, 1'b0);
        chk("arst_done_cnt", o_done_cnt, '0);
        chk("arst_err_cnt", o_err_cnt, '0);
        chk("arst_max_timeout", o_max_timeout, '0);
        exp_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (o_cmd_done !== 1'b0 || o_wait_en !== '0) seen_done = 1'b1;
            tick;
        end
        chk("post_rst_quiet", seen_done, 1'b0);
        push_cmd(3'd6, 1'b1, 32'd15);
        issue(1);
        finish_cmd(0, 4);

        // Randomized commands
        for (int n = 0; n < 10; n++) begin
            s  = 3'($urandom_range(0, 7));
            e  = 1'($urandom_range(0, 1));
            to = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
            if (to == 0) dd = $urandom_range(0, 40);
            else if ($urandom_range(0, 3) == 0) dd = -1;
            else dd = $urandom_range(0, int'(to) + GC + 4);
            push_cmd(s, e, to);
            issue(1);
            finish_cmd(0, dd);
        end

`ifdef WAIT_EVENT_SEQ_ABORT_EN
        // Abort during a wait with two queued
        push_cmd(3'd1, 1'b0, 32'd0);
        issue(1);
        push_cmd(3'd2, 1'b1, 32'd10);
        push_cmd(3'd3, 1'b1, 32'd10);
        i_abort = 1'b1;
        #1;
        chk("abort_ready_low", o_cmd_ready, 1'b0);
        tick;
        i_abort = 1'b0;
        exp_q.delete();
        exp_err++;
        chk("abort_cmd_done", o_cmd_done, 1'b1);
        chk("abort_cmd_err", o_cmd_err, 1'b1);
        tick;
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_err_cnt", o_err_cnt, exp_err);
        chk("abort_done_cnt", o_done_cnt, exp_ok);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
